// File: rtl/fp64_pkg.sv
// Shared binary64 field definitions and helpers used by the integer/FP conversion blocks.
package fp64_pkg;

  localparam int unsigned FP64_BIAS   = 1023;
  localparam int unsigned FP64_EXP_W  = 11;
  localparam int unsigned FP64_FRAC_W = 52;
  localparam int unsigned FP64_W      = 1 + FP64_EXP_W + FP64_FRAC_W;

  typedef struct packed {
    logic                   sign;
    logic [FP64_EXP_W-1:0]  exp;
    logic [FP64_FRAC_W-1:0] frac;
  } fp64_t;

  // Leading-zero count of a 64-bit word; an all-zero word reports 63.
  function automatic logic [5:0] lzc64(input logic [63:0] v);
    logic [5:0] cnt;
    cnt = 6'd63;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) cnt = 6'(63 - i);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lzc64.sv
// Combinational 64-bit leading-zero counter with an all-zero flag.
module lzc64 (
  input  logic [63:0] i_data,
  output logic [5:0]  o_count_c,
  output logic        o_zero_c
);

  assign o_count_c = fp64_pkg::lzc64(i_data);
  assign o_zero_c  = ~|i_data;

endmodule

// File: rtl/int_to_double.sv
// 64-bit integer to binary64 converter, round-to-nearest-even, three elastic
// pipeline stages with valid/ready handshakes on both sides.
module int_to_double
  import fp64_pkg::*;
#(
  parameter bit          INPUT_SIGNED   = 1'b1,
  parameter int unsigned OUTPUT_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_tvalid,
  input  logic [63:0] a_tdata,
  output logic        a_tready,
  output logic        result_tvalid,
  output logic [63:0] result_tdata,
  input  logic        result_tready
);

  generate
    if (OUTPUT_LATENCY != 3) begin : g_bad_latency
      $error("int_to_double: OUTPUT_LATENCY must be 3");
    end
  endgenerate

  localparam int unsigned KEEP_W = FP64_FRAC_W + 1;

  logic                  r_v1, r_v2, r_v3;
  logic                  w_ld1, w_ld2, w_ld3;

  logic                  r_sign1;
  logic [63:0]           r_mag1;
  logic                  r_sign2;
  logic                  r_zero2;
  logic [63:0]           r_norm2;
  logic [FP64_EXP_W-1:0] r_exp2;
  logic [63:0]           r_res;

  logic                  w_sign;
  logic [63:0]           w_mag;
  logic [5:0]            w_lzc;
  logic                  w_lz_zero;

  logic [KEEP_W-1:0]      w_kept;
  logic                   w_guard;
  logic                   w_sticky;
  logic                   w_round_up;
  logic [KEEP_W:0]        w_sum;
  logic                   w_carry;
  logic [FP64_FRAC_W-1:0] w_frac;
  logic [FP64_EXP_W-1:0]  w_exp;
  fp64_t                  w_packed;

  // A stage loads when empty or when its contents move on this cycle.
  assign w_ld3    = !r_v3 || result_tready;
  assign w_ld2    = !r_v2 || w_ld3;
  assign w_ld1    = !r_v1 || w_ld2;
  assign a_tready = w_ld1;

  assign w_sign = INPUT_SIGNED & a_tdata[63];
  assign w_mag  = w_sign ? (~a_tdata + 64'd1) : a_tdata;

  lzc64 u_lzc (
    .i_data    (r_mag1),
    .o_count_c (w_lzc),
    .o_zero_c  (w_lz_zero)
  );

  // Rounding: a carry out of the 53-bit significand renormalises by one place.
  assign w_kept     = r_norm2[63:11];
  assign w_guard    = r_norm2[10];
  assign w_sticky   = |r_norm2[9:0];
  assign w_round_up = w_guard & (w_sticky | w_kept[0]);
  assign w_sum      = {1'b0, w_kept} + (KEEP_W+1)'(w_round_up);
  assign w_carry    = w_sum[KEEP_W];
  assign w_frac     = w_carry ? w_sum[KEEP_W-1:1] : w_sum[FP64_FRAC_W-1:0];
  assign w_exp      = r_exp2 + FP64_EXP_W'(w_carry);

  always_comb begin
    w_packed = '0;
    if (!r_zero2) begin
      w_packed.sign = r_sign2;
      w_packed.exp  = w_exp;
      w_packed.frac = w_frac;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_res <= '0;
    end else begin
      if (w_ld1) r_v1 <= a_tvalid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_ld3 && r_v2) r_res <= w_packed;
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_ld1 && a_tvalid) begin
      r_sign1 <= w_sign;
      r_mag1  <= w_mag;
    end
    if (w_ld2 && r_v1) begin
      r_sign2 <= r_sign1;
      r_zero2 <= w_lz_zero;
      r_norm2 <= r_mag1 << w_lzc;
      r_exp2  <= FP64_EXP_W'(FP64_BIAS + 63) - FP64_EXP_W'(w_lzc);
    end
  end

  assign result_tvalid = r_v3;
  assign result_tdata  = r_res;

endmodule
